// File: rtl/mm_host_driver_pkg.sv
// Shared types and helpers for the matrix-multiply host driver:
// controller states, result-word geometry and the result-word select.
package mm_host_driver_pkg;

  localparam int W          = 16;
  localparam int NUM_RES    = 16;
  localparam int RES_WORD_W = 4 * W;
  localparam int RES_IDX_W  = $clog2(NUM_RES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_ACK
  } state_t;

  // Word k of the flattened result bus; word k sits at bits [RES_WORD_W*k +: RES_WORD_W].
  function automatic logic [RES_WORD_W-1:0] result_word(
    input logic [NUM_RES*RES_WORD_W-1:0] res,
    input logic [RES_IDX_W-1:0]          k
  );
    return res[int'(k)*RES_WORD_W +: RES_WORD_W];
  endfunction

endpackage

// File: rtl/mm_host_driver.sv
// Host-side initiator for the MMIO matrix-multiply accelerator: loads operand
// rows, starts the multiply, streams the 16 result words out, then releases it.
module mm_host_driver
  import mm_host_driver_pkg::*;
#(
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int LOAD_DEPTH      = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [4*SRAM_DATA_WIDTH-1:0]    in_data,
  output logic [ADDR_WIDTH-1:0]           sram_raddr,
  output logic [SRAM_DATA_WIDTH-1:0]      sram_rdata_a0,
  output logic [SRAM_DATA_WIDTH-1:0]      sram_rdata_a1,
  output logic [SRAM_DATA_WIDTH-1:0]      sram_rdata_b0,
  output logic [SRAM_DATA_WIDTH-1:0]      sram_rdata_b1,
  output logic                            mm_input_valid,
  input  logic                            mm_input_ready,
  input  logic                            mm_output_valid,
  output logic                            mm_output_ready,
  input  logic [NUM_RES*RES_WORD_W-1:0]   mm_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RES_WORD_W-1:0]           out_data,
  output logic [3:0]                      out_index,
  output logic                            out_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(LOAD_DEPTH - 1);
  localparam logic [RES_IDX_W-1:0]  LAST_K   = RES_IDX_W'(NUM_RES - 1);

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            row_q, row_d;
  logic [ADDR_WIDTH-1:0]            raddr_q, raddr_d;
  logic [4*SRAM_DATA_WIDTH-1:0]     lanes_q, lanes_d;
  logic [RES_IDX_W-1:0]             k_q, k_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      raddr_q <= '0;
      lanes_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      raddr_q <= raddr_d;
      lanes_q <= lanes_d;
      k_q     <= k_d;
    end
  end

  // The accelerator writes its operand memory every cycle, so the address and
  // lanes move only on an accepted beat and otherwise re-present the last row.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    raddr_d = raddr_q;
    lanes_d = lanes_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        row_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_valid) begin
          raddr_d = row_q;
          lanes_d = in_data;
          row_d   = row_q + 1'b1;
          if (row_q == LAST_ROW) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_START;
      ST_START: begin
        if (mm_input_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        k_d = '0;
        if (mm_output_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_K) state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_ACK);
  assign in_ready        = (state_q == ST_LOAD);
  assign mm_input_valid  = (state_q == ST_START);
  assign mm_output_ready = (state_q == ST_ACK);
  assign out_valid       = (state_q == ST_DRAIN);

  // Result beat is a combinational select, forced to zero outside DRAIN.
  assign out_data  = out_valid ? result_word(mm_result, k_q) : '0;
  assign out_index = out_valid ? k_q : '0;
  assign out_last  = out_valid && (k_q == LAST_K);

  assign sram_raddr    = raddr_q;
  assign sram_rdata_a0 = lanes_q[4*SRAM_DATA_WIDTH-1 -: SRAM_DATA_WIDTH];
  assign sram_rdata_a1 = lanes_q[3*SRAM_DATA_WIDTH-1 -: SRAM_DATA_WIDTH];
  assign sram_rdata_b0 = lanes_q[2*SRAM_DATA_WIDTH-1 -: SRAM_DATA_WIDTH];
  assign sram_rdata_b1 = lanes_q[SRAM_DATA_WIDTH-1 -: SRAM_DATA_WIDTH];

endmodule

// File: tb/tb_mm_host_driver.sv
// Directed testbench for mm_host_driver: the bench plays both the host streams
// and the accelerator, and compares against hand-derived expectations.
module tb_mm_host_driver;

  localparam int SDW = 32;
  localparam int AW  = 10;
  localparam int LD  = 256;
  localparam int RW  = 64;
  localparam int NR  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            busy, done;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4*SDW-1:0] in_data = '0;
  logic [AW-1:0]   sram_raddr;
  logic [SDW-1:0]  sram_rdata_a0, sram_rdata_a1, sram_rdata_b0, sram_rdata_b1;
  logic            mm_input_valid;
  logic            mm_input_ready = 1'b1;
  logic            mm_output_valid = 1'b0;
  logic            mm_output_ready;
  logic [NR*RW-1:0] mm_result = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [RW-1:0]   out_data;
  logic [3:0]      out_index;
  logic            out_last;

  logic [4*SDW-1:0] lanes;
  logic [212:0]     all_outs;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  logic [AW-1:0]    obs_addr[LD];
  logic [4*SDW-1:0] obs_lanes[LD];
  int               load_accepts, load_cycles, gap_cycles, hold_changes;
  logic             start_iv, wait_iv;
  logic             obs_iv[16];
  logic [3:0]       obs_wait_sig;
  logic [3:0]       obs_idx[NR];
  logic [RW-1:0]    obs_data[NR];
  logic             obs_last[NR];
  int               drain_beats, stall_n;
  logic             drain_mor;
  logic [RW-1:0]    stall_data[8];
  logic [3:0]       stall_idx[8];
  logic             ack_mor, ack_done, idle_busy, idle_done, idle_mor;

  mm_host_driver #(
    .SRAM_DATA_WIDTH(SDW),
    .ADDR_WIDTH     (AW),
    .LOAD_DEPTH     (LD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .sram_raddr     (sram_raddr),
    .sram_rdata_a0  (sram_rdata_a0),
    .sram_rdata_a1  (sram_rdata_a1),
    .sram_rdata_b0  (sram_rdata_b0),
    .sram_rdata_b1  (sram_rdata_b1),
    .mm_input_valid (mm_input_valid),
    .mm_input_ready (mm_input_ready),
    .mm_output_valid(mm_output_valid),
    .mm_output_ready(mm_output_ready),
    .mm_result      (mm_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last)
  );

  assign lanes    = {sram_rdata_a0, sram_rdata_a1, sram_rdata_b0, sram_rdata_b1};
  assign all_outs = {busy, done, in_ready, mm_input_valid, mm_output_ready, out_valid,
                     out_last, out_index, out_data, sram_raddr, lanes};

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_count++;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish before 500000");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [4*SDW-1:0] row_word(input int r);
    return {32'(r), 32'(r + 1), 32'(r + 2), 32'(r + 3)};
  endfunction

  function automatic logic [RW-1:0] exp_word(input int k);
    return {16'(k * 3 + 1), 16'(16'h55AA ^ k), 16'(k + 100), 16'hBEEF};
  endfunction

  // Stimulus helpers only record observations; each test task judges them.
  task automatic start_job();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic do_load(input bit stall_pat);
    int r, cyc;
    logic [AW-1:0] pa;
    logic [4*SDW-1:0] pl;
    logic rdy;
    r = 0; cyc = 0; gap_cycles = 0; hold_changes = 0;
    while (r < LD && cyc < 4 * LD + 16) begin
      @(negedge clock);
      in_valid = stall_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      in_data  = row_word(r);
      rdy = in_ready; pa = sram_raddr; pl = lanes;
      @(posedge clock); #1;
      if (in_valid && rdy) begin
        obs_addr[r]  = sram_raddr;
        obs_lanes[r] = lanes;
        r++;
      end else begin
        gap_cycles++;
        if (sram_raddr !== pa || lanes !== pl) hold_changes++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    load_accepts = r;
    load_cycles  = cyc;
  endtask

  task automatic do_start(input int not_ready);
    @(posedge clock); #1;
    start_iv = mm_input_valid;
    for (int i = 0; i < not_ready && i < 16; i++) begin
      @(negedge clock);
      obs_iv[i] = mm_input_valid;
      @(posedge clock); #1;
    end
    @(negedge clock);
    mm_input_ready = 1'b1;
    @(posedge clock); #1;
    wait_iv = mm_input_valid;
  endtask

  task automatic do_result(input int lat, input bit pulse);
    obs_wait_sig = '0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clock);
      start = pulse && (i == 1);
      obs_wait_sig = obs_wait_sig | {!busy, in_ready, mm_input_valid, out_valid};
      @(posedge clock); #1;
    end
    start = 1'b0;
    @(negedge clock);
    mm_output_valid = 1'b1;
    mm_input_ready  = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_drain(input int stall_at, input int stall_len, input int max_beats);
    int cyc;
    drain_beats = 0; stall_n = 0; cyc = 0; drain_mor = 1'b0;
    while (drain_beats < max_beats && cyc < 200) begin
      @(negedge clock);
      drain_mor = drain_mor | mm_output_ready;
      if (drain_beats == stall_at && stall_n < stall_len) begin
        out_ready = 1'b0;
        stall_data[stall_n] = out_data;
        stall_idx[stall_n]  = out_index;
        stall_n++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        obs_idx[drain_beats]  = out_index;
        obs_data[drain_beats] = out_data;
        obs_last[drain_beats] = out_last;
        drain_beats++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic do_ack();
    ack_mor  = mm_output_ready;
    ack_done = done;
    @(negedge clock);
    mm_output_valid = 1'b0;
    mm_input_ready  = 1'b1;
    @(posedge clock); #1;
    idle_busy = busy; idle_done = done; idle_mor = mm_output_ready;
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %0h expected 0", all_outs);
    end
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_full_job();
    int d0;
    d0 = done_count;
    start_job();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++; $display("[TB] FAIL load_entry: got %b expected 11", {busy, in_ready});
    end
    do_load(1'b0);
    checks++;
    if (load_accepts != LD || load_cycles != LD) begin
      errors++; $display("[TB] FAIL load_count: got %0d beats in %0d cycles expected %0d in %0d",
                         load_accepts, load_cycles, LD, LD);
    end
    for (int r = 0; r < LD; r++) begin
      checks++;
      if (obs_addr[r] !== AW'(r) || obs_lanes[r] !== row_word(r)) begin
        errors++; $display("[TB] FAIL load_row%0d: got addr %0d lanes %h expected addr %0d lanes %h",
                           r, obs_addr[r], obs_lanes[r], r, row_word(r));
      end
    end
    checks++;
    if ({mm_input_valid, in_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL settle: got %b expected 00", {mm_input_valid, in_ready});
    end
    do_start(0);
    checks++;
    if ({start_iv, wait_iv} !== 2'b10) begin
      errors++; $display("[TB] FAIL start_handshake: got %b expected 10", {start_iv, wait_iv});
    end
    do_result(3, 1'b0);
    checks++;
    if (obs_wait_sig !== 4'b0000 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL wait_to_drain: got %b/%b expected 0000/1", obs_wait_sig, out_valid);
    end
    do_drain(99, 0, NR);
    checks++;
    if (drain_beats != NR || drain_mor !== 1'b0) begin
      errors++; $display("[TB] FAIL drain_count: got %0d beats mor %b expected %0d beats mor 0",
                         drain_beats, drain_mor, NR);
    end
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (obs_idx[k] !== 4'(k) || obs_data[k] !== exp_word(k) || obs_last[k] !== (k == NR - 1)) begin
        errors++; $display("[TB] FAIL drain_beat%0d: got idx %0d data %h last %b expected idx %0d data %h last %b",
                           k, obs_idx[k], obs_data[k], obs_last[k], k, exp_word(k), (k == NR - 1));
      end
    end
    do_ack();
    checks++;
    if ({ack_mor, ack_done} !== 2'b11) begin
      errors++; $display("[TB] FAIL ack_pulse: got %b expected 11", {ack_mor, ack_done});
    end
    checks++;
    if ({idle_busy, idle_done, idle_mor} !== 3'b000) begin
      errors++; $display("[TB] FAIL back_to_idle: got %b expected 000", {idle_busy, idle_done, idle_mor});
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_count - d0);
    end
    checks++;
    if (sram_raddr !== AW'(LD - 1) || lanes !== row_word(LD - 1)) begin
      errors++; $display("[TB] FAIL idle_hold: got addr %0d lanes %h expected addr %0d lanes %h",
                         sram_raddr, lanes, LD - 1, row_word(LD - 1));
    end
  endtask

  task automatic test_input_stalls();
    int d0, bad;
    d0 = done_count;
    start_job();
    do_load(1'b1);
    checks++;
    if (load_accepts != LD || load_cycles != 2 * LD || gap_cycles != LD) begin
      errors++; $display("[TB] FAIL stall_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         load_accepts, load_cycles, gap_cycles, LD, 2 * LD, LD);
    end
    checks++;
    if (hold_changes != 0) begin
      errors++; $display("[TB] FAIL stall_hold: got %0d changes during gaps expected 0", hold_changes);
    end
    bad = 0;
    for (int r = 0; r < LD; r++)
      if (obs_addr[r] !== AW'(r) || obs_lanes[r] !== row_word(r)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL stall_rows: got %0d wrong rows expected 0", bad);
    end
    do_start(0);
    do_result(2, 1'b0);
    do_drain(99, 0, NR);
    do_ack();
    checks++;
    if (done_count - d0 != 1) begin
      errors++; $display("[TB] FAIL stall_done_count: got %0d expected 1", done_count - d0);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    d0 = done_count;
    start_job();
    do_load(1'b0);
    do_start(0);
    do_result(3, 1'b0);
    do_drain(7, 5, NR);
    checks++;
    if (stall_n != 5 || drain_beats != NR || drain_mor !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_counts: got stalls %0d beats %0d mor %b expected 5 %0d 0",
                         stall_n, drain_beats, drain_mor, NR);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (stall_data[i] !== exp_word(7) || stall_idx[i] !== 4'd7) begin
        errors++; $display("[TB] FAIL bp_hold%0d: got idx %0d data %h expected idx 7 data %h",
                           i, stall_idx[i], stall_data[i], exp_word(7));
      end
    end
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (obs_idx[k] !== 4'(k) || obs_data[k] !== exp_word(k)) begin
        errors++; $display("[TB] FAIL bp_beat%0d: got idx %0d data %h expected idx %0d data %h",
                           k, obs_idx[k], obs_data[k], k, exp_word(k));
      end
    end
    do_ack();
    checks++;
    if (done_count - d0 != 1) begin
      errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", done_count - d0);
    end
  endtask

  task automatic test_accel_not_ready();
    int d0, low;
    d0 = done_count;
    mm_input_ready = 1'b0;
    start_job();
    do_load(1'b0);
    do_start(10);
    low = 0;
    for (int i = 0; i < 10; i++) if (obs_iv[i] !== 1'b1) low++;
    checks++;
    if (start_iv !== 1'b1 || low != 0) begin
      errors++; $display("[TB] FAIL nr_held: got first %b dropped %0d expected first 1 dropped 0",
                         start_iv, low);
    end
    checks++;
    if ({wait_iv, busy, out_valid} !== 3'b010) begin
      errors++; $display("[TB] FAIL nr_advance: got %b expected 010", {wait_iv, busy, out_valid});
    end
    do_result(3, 1'b0);
    do_drain(99, 0, NR);
    do_ack();
    checks++;
    if (done_count - d0 != 1 || drain_beats != NR) begin
      errors++; $display("[TB] FAIL nr_done: got done %0d beats %0d expected 1 %0d",
                         done_count - d0, drain_beats, NR);
    end
  endtask

  task automatic test_reset_mid_drain();
    int d0;
    d0 = done_count;
    start_job();
    do_load(1'b0);
    do_start(0);
    do_result(3, 1'b0);
    do_drain(99, 0, 9);
    checks++;
    if (out_index !== 4'd9 || out_data !== exp_word(9)) begin
      errors++; $display("[TB] FAIL pre_reset_k: got idx %0d data %h expected 9 %h",
                         out_index, out_data, exp_word(9));
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("[TB] FAIL async_reset: got %0h expected 0", all_outs);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mm_output_valid = 1'b0;
    mm_input_ready  = 1'b1;
    checks++;
    if (done_count != d0) begin
      errors++; $display("[TB] FAIL reset_no_done: got %0d done pulses expected 0", done_count - d0);
    end
    start_job();
    do_load(1'b0);
    do_start(0);
    do_result(3, 1'b0);
    do_drain(99, 0, NR);
    checks++;
    if (drain_beats != NR || obs_idx[0] !== 4'd0 || obs_data[NR - 1] !== exp_word(NR - 1)) begin
      errors++; $display("[TB] FAIL rerun_drain: got beats %0d idx0 %0d last %h expected %0d 0 %h",
                         drain_beats, obs_idx[0], obs_data[NR - 1], NR, exp_word(NR - 1));
    end
    do_ack();
    checks++;
    if (done_count - d0 != 1) begin
      errors++; $display("[TB] FAIL rerun_done: got %0d expected 1", done_count - d0);
    end
  endtask

  task automatic test_start_in_wait();
    int d0;
    d0 = done_count;
    start_job();
    do_load(1'b0);
    do_start(0);
    do_result(4, 1'b1);
    checks++;
    if (obs_wait_sig !== 4'b0000 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL wait_start_ignored: got %b/%b expected 0000/1", obs_wait_sig, out_valid);
    end
    do_drain(99, 0, NR);
    do_ack();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (done_count - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL wait_no_restart: got done %0d busy %b expected 1 0",
                         done_count - d0, busy);
    end
  endtask

  initial begin
    for (int k = 0; k < NR; k++) mm_result[RW*k +: RW] = exp_word(k);
    test_reset();
    test_full_job();
    test_input_stalls();
    test_backpressure();
    test_accel_not_ready();
    test_reset_mid_drain();
    test_start_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
